// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches over a valid/ready
// request channel, captures the in-order response and holds it for decode.
// Redirects from downstream restart fetch; a response already in flight when
// a redirect lands is discarded via the drop flag.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  // State register; reset takes priority over every handshake and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC[XLEN-1:0];
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state logic; a redirect overrides every other event in its cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_req_ready) begin
            // Request left with the old PC; its response must be thrown away.
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d    = mem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == ST_HOLD);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule
